pc_fetch_sequencer: RTL and testbench

//  Produces the PC sequence and drives the instruction-memory fetch port. It is the

---
 rtl/mips_fetch_pkg.sv | 17 +
 rtl/fetch_fifo2.sv | 64 ++++++
 rtl/pc_fetch_sequencer.sv | 105 ++++++++++
 tb/tb_pc_fetch_sequencer.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_fetch_pkg.sv
// Shared definitions for the MIPS instruction-fetch path: default widths,
// reset vector, PC increment and the fetch sequencer state encoding.
package mips_fetch_pkg;

    localparam int          ADDR_W_DEF       = 32;
    localparam int          DATA_W_DEF       = 32;
    localparam logic [31:0] RESET_VECTOR_DEF = 32'h0000_0000;
    localparam int          PC_INC           = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DROP = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/fetch_fifo2.sv
// Two-entry {pc, instr} queue between the fetch port and decode.
// Flush dominates push and pop; a pop on an empty queue is ignored.
module fetch_fifo2 #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [ADDR_W-1:0] push_pc,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    input  logic              flush,
    output logic              vld,
    output logic [ADDR_W-1:0] head_pc,
    output logic [DATA_W-1:0] head_data,
    output logic [1:0]        count
);

    logic [ADDR_W-1:0] pc_q   [2];
    logic [DATA_W-1:0] data_q [2];
    logic              wr_ptr;
    logic              rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign do_pop  = pop && (count != 2'd0);
    assign do_push = push && ((count != 2'd2) || do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count  <= 2'd0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                pc_q[i]   <= '0;
                data_q[i] <= '0;
            end
        end else if (flush) begin
            count  <= 2'd0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
        end else begin
            if (do_push) begin
                pc_q[wr_ptr]   <= push_pc;
                data_q[wr_ptr] <= push_data;
                wr_ptr         <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    assign vld       = (count != 2'd0);
    assign head_pc   = pc_q[rd_ptr];
    assign head_data = data_q[rd_ptr];

endmodule

// File: rtl/pc_fetch_sequencer.sv
// Next-PC generation and instruction-memory fetch sequencing with a
// two-entry decode buffer; redirects flush the buffer and squash in-flight data.
module pc_fetch_sequencer
    import mips_fetch_pkg::*;
#(
    parameter int                ADDR_W       = ADDR_W_DEF,
    parameter int                DATA_W       = DATA_W_DEF,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = ADDR_W'(RESET_VECTOR_DEF)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_gnt,
    input  logic              imem_rvalid,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [DATA_W-1:0] instr_data,
    output logic [ADDR_W-1:0] instr_pc
);

    fetch_state_t      state;
    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] inflight_pc;
    logic [ADDR_W-1:0] redir_pc;
    logic [1:0]        fifo_cnt;
    logic              outstanding;
    logic              credit;
    logic              req;
    logic              gnt_hit;
    logic              push;

    // A slot is reserved for every issued request, so in-flight data always fits.
    assign outstanding = (state == ST_WAIT) || (state == ST_DROP);
    assign credit      = ({1'b0, fifo_cnt} + {2'b00, outstanding}) < 3'd2;
    assign req         = (state == ST_REQ) && credit;
    assign gnt_hit     = req && imem_gnt;
    assign push        = (state == ST_WAIT) && imem_rvalid && !redirect_valid;
    assign redir_pc    = redirect_pc & ~ADDR_W'(3);

    assign imem_req  = req;
    assign imem_addr = fetch_pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            fetch_pc <= RESET_VECTOR;
        end else begin
            case (state)
                ST_IDLE: begin
                    state <= ST_REQ;
                    if (redirect_valid) fetch_pc <= redir_pc;
                end
                ST_REQ: begin
                    if (redirect_valid) begin
                        fetch_pc <= redir_pc;
                        if (gnt_hit) state <= ST_DROP;
                    end else if (gnt_hit) begin
                        fetch_pc <= fetch_pc + ADDR_W'(PC_INC);
                        state    <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (redirect_valid) begin
                        fetch_pc <= redir_pc;
                        state    <= imem_rvalid ? ST_REQ : ST_DROP;
                    end else if (imem_rvalid) begin
                        state <= ST_REQ;
                    end
                end
                ST_DROP: begin
                    if (redirect_valid) fetch_pc <= redir_pc;
                    if (imem_rvalid)    state    <= ST_REQ;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Address of the request in flight, paired with its response on push.
    always_ff @(posedge clk) begin
        if (gnt_hit) inflight_pc <= fetch_pc;
    end

    fetch_fifo2 #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_pc   (inflight_pc),
        .push_data (imem_rdata),
        .pop       (instr_ready),
        .flush     (redirect_valid),
        .vld       (instr_valid),
        .head_pc   (instr_pc),
        .head_data (instr_data),
        .count     (fifo_cnt)
    );

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Directed bench for pc_fetch_sequencer: cycle-level memory responder,
// address-sequence model and an expected-instruction scoreboard.
module tb_pc_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr_data;
    logic [31:0] instr_pc;

    always #5 clk = ~clk;

    pc_fetch_sequencer #(
        .ADDR_W       (32),
        .DATA_W       (32),
        .RESET_VECTOR (32'h0000_0000)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr_data     (instr_data),
        .instr_pc       (instr_pc)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data;
    } ent_t;

    int          total = 0;
    int          passed = 0;
    logic        gnt_en, rsp_hold, stray, redir_now;
    logic [31:0] redir_tgt;
    int          lat;
    logic        pending, plive;
    logic [31:0] paddr;
    int          wcnt;
    logic [31:0] exp_addr;
    ent_t        expq[$];
    int          consumed, n_issued;
    logic [31:0] seen_pc[$];
    logic [31:0] gnt_log[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hC0DE_0000 ^ {a[7:0], 24'h0};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // One clock: drive inputs, let the edge happen, then update the model at edge+1.
    task automatic tick();
        logic        s_req, s_gnt, s_rv, s_iv, s_ir, s_redir, was_pend;
        logic [31:0] s_addr, s_ipc, s_idata, s_tgt;
        ent_t        e;
        imem_gnt       = gnt_en;
        imem_rvalid    = (pending && wcnt == 1 && !rsp_hold) || stray;
        imem_rdata     = pending ? mem_word(paddr) : 32'hDEAD_BEEF;
        redirect_valid = redir_now;
        redirect_pc    = redir_tgt;
        s_req = imem_req;    s_addr = imem_addr;  s_gnt = imem_gnt;
        s_rv  = imem_rvalid; s_iv   = instr_valid; s_ir = instr_ready;
        s_ipc = instr_pc;    s_idata = instr_data;
        s_redir = redir_now; s_tgt = redir_tgt;
        @(posedge clk);
        #1;
        if (s_iv && s_ir) begin
            consumed++;
            seen_pc.push_back(s_ipc);
            if (expq.size() == 0) begin
                chk("extra_instr", 32'(expq.size()), 32'd1);
            end else begin
                e = expq.pop_front();
                chk("instr_pc", s_ipc, e.pc);
                chk("instr_data", s_idata, e.data);
            end
        end
        if (s_redir) expq.delete();
        was_pend = pending;
        if (s_rv && was_pend) begin
            if (plive && !s_redir) begin
                e.pc   = paddr;
                e.data = mem_word(paddr);
                expq.push_back(e);
                chk("rsp_to_valid", 32'(instr_valid), 32'd1);
            end
            pending = 1'b0;
        end else if (was_pend && s_redir) begin
            plive = 1'b0;
        end
        if (was_pend && pending && !rsp_hold && wcnt > 1) wcnt--;
        if (s_req && s_gnt) begin
            chk("gnt_addr", s_addr, exp_addr);
            n_issued++;
            gnt_log.push_back(s_addr);
            pending  = 1'b1;
            plive    = !s_redir;
            paddr    = s_addr;
            wcnt     = lat;
            exp_addr = s_redir ? (s_tgt & ~32'd3) : s_addr + 32'd4;
        end else if (s_redir) begin
            exp_addr = s_tgt & ~32'd3;
        end
        redir_now = 1'b0;
        stray     = 1'b0;
    endtask

    task automatic model_reset();
        pending  = 1'b0;
        plive    = 1'b0;
        wcnt     = 0;
        expq.delete();
        exp_addr = 32'h0;
        rsp_hold = 1'b0;
        redir_now = 1'b0;
        stray    = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        redirect_valid = 1'b0; redirect_pc = '0;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
        instr_ready = 1'b1;
        gnt_en = 1'b0; redir_tgt = '0; lat = 1;
        consumed = 0; n_issued = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_data", instr_data, 32'h0);
        chk("rst_pc", instr_pc, 32'h0);
        rst_n = 1'b1;
        chk("rel_req0", 32'(imem_req), 32'd0);
        tick();
        chk("rel_req1", 32'(imem_req), 32'd1);

        // Streaming fetch with one-cycle response latency.
        gnt_en = 1'b1; consumed = 0; seen_pc.delete();
        for (int i = 0; i < 60 && consumed < 4; i++) tick();
        chk("t1_count", 32'(consumed), 32'd4);
        if (seen_pc.size() >= 4)
            for (int i = 0; i < 4; i++) chk("t1_seq", seen_pc[i], 32'(4 * i));

        // Back-pressure: two requests fill the queue, then fetch stalls.
        do_reset();
        gnt_en = 1'b1; instr_ready = 1'b0; n_issued = 0;
        repeat (10) tick();
        chk("t2_issued", 32'(n_issued), 32'd2);
        chk("t2_req_low", 32'(imem_req), 32'd0);
        chk("t2_valid", 32'(instr_valid), 32'd1);
        chk("t2_head_pc", instr_pc, 32'h0);
        instr_ready = 1'b1; gnt_log.delete(); consumed = 0; seen_pc.delete();
        tick();
        chk("t2_next_head", instr_pc, 32'h4);
        for (int i = 0; i < 60 && consumed < 4; i++) tick();
        chk("t2_count", 32'(consumed), 32'd4);
        if (gnt_log.size() >= 1) chk("t2_resume_addr", gnt_log[0], 32'h8);
        if (seen_pc.size() >= 4)
            for (int i = 0; i < 4; i++) chk("t2_seq", seen_pc[i], 32'(4 * i));

        // Redirect while a response for 0x10 is outstanding.
        do_reset();
        gnt_en = 1'b0; instr_ready = 1'b1;
        tick();
        redir_now = 1'b1; redir_tgt = 32'h10;
        tick();
        chk("t3_addr_10", imem_addr, 32'h10);
        rsp_hold = 1'b1; gnt_en = 1'b1;
        tick();
        gnt_en = 1'b0;
        repeat (2) tick();
        chk("t3_wait_req", 32'(imem_req), 32'd0);
        redir_now = 1'b1; redir_tgt = 32'h0000_0102;
        tick();
        chk("t3_drop_req", 32'(imem_req), 32'd0);
        chk("t3_drop_valid", 32'(instr_valid), 32'd0);
        rsp_hold = 1'b0;
        tick();
        chk("t3_next_addr", imem_addr, 32'h100);
        chk("t3_req", 32'(imem_req), 32'd1);
        gnt_en = 1'b1; consumed = 0; seen_pc.delete();
        for (int i = 0; i < 40 && consumed < 2; i++) tick();
        chk("t3_count", 32'(consumed), 32'd2);
        if (seen_pc.size() >= 2) begin
            chk("t3_pc0", seen_pc[0], 32'h100);
            chk("t3_pc1", seen_pc[1], 32'h104);
        end

        // Redirect coinciding with the response.
        gnt_en = 1'b0;
        for (int i = 0; i < 20 && (pending || instr_valid); i++) tick();
        rsp_hold = 1'b1; gnt_en = 1'b1;
        for (int i = 0; i < 10 && !pending; i++) tick();
        chk("t4_pending", 32'(pending), 32'd1);
        gnt_en = 1'b0; rsp_hold = 1'b0;
        redir_now = 1'b1; redir_tgt = 32'h200;
        tick();
        chk("t4_valid", 32'(instr_valid), 32'd0);
        chk("t4_addr", imem_addr, 32'h200);
        chk("t4_req", 32'(imem_req), 32'd1);

        // Redirect with the queue full.
        instr_ready = 1'b0; gnt_en = 1'b1;
        for (int i = 0; i < 30 && !(instr_valid && !imem_req && !pending); i++) tick();
        chk("t4_full_valid", 32'(instr_valid), 32'd1);
        chk("t4_full_req", 32'(imem_req), 32'd0);
        gnt_en = 1'b0; redir_now = 1'b1; redir_tgt = 32'h300;
        tick();
        chk("t4_flush_valid", 32'(instr_valid), 32'd0);
        chk("t4_flush_addr", imem_addr, 32'h300);

        // Address wrap at the top of the address space.
        instr_ready = 1'b1; redir_now = 1'b1; redir_tgt = 32'hFFFF_FFF8;
        tick();
        gnt_log.delete(); consumed = 0; seen_pc.delete(); gnt_en = 1'b1;
        for (int i = 0; i < 60 && consumed < 3; i++) tick();
        chk("t5_count", 32'(consumed), 32'd3);
        if (gnt_log.size() >= 3) begin
            chk("t5_gnt0", gnt_log[0], 32'hFFFF_FFF8);
            chk("t5_gnt1", gnt_log[1], 32'hFFFF_FFFC);
            chk("t5_gnt2", gnt_log[2], 32'h0000_0000);
        end
        if (seen_pc.size() >= 3) chk("t5_pc2", seen_pc[2], 32'h0);

        // Asynchronous reset while a response is outstanding.
        instr_ready = 1'b0; gnt_en = 1'b1; rsp_hold = 1'b0;
        for (int i = 0; i < 20 && !instr_valid; i++) tick();
        rsp_hold = 1'b1;
        for (int i = 0; i < 10 && !pending; i++) tick();
        gnt_en = 1'b0;
        tick();
        chk("t6_pre_valid", 32'(instr_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t6_req", 32'(imem_req), 32'd0);
        chk("t6_addr", imem_addr, 32'h0);
        chk("t6_valid", 32'(instr_valid), 32'd0);
        chk("t6_pc", instr_pc, 32'h0);
        chk("t6_data", instr_data, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        stray = 1'b1;
        tick();
        stray = 1'b1;
        tick();
        chk("t6_stray_valid", 32'(instr_valid), 32'd0);
        chk("t6_stray_req", 32'(imem_req), 32'd1);
        gnt_log.delete(); consumed = 0; seen_pc.delete();
        instr_ready = 1'b1; gnt_en = 1'b1;
        for (int i = 0; i < 30 && consumed < 1; i++) tick();
        chk("t6_count", 32'(consumed), 32'd1);
        if (gnt_log.size() >= 1) chk("t6_first_gnt", gnt_log[0], 32'h0);
        if (seen_pc.size() >= 1) chk("t6_first_pc", seen_pc[0], 32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
